// File: rtl/display_sequencer.sv
// display_sequencer: display startup/mode-switch sequencer with lock recovery; define DISPLAY_SEQ_TIMEOUT_EN for a WAIT_LOCK retry timeout
module display_sequencer #(
  parameter int RST_CYCLES = 16,
  parameter int SETTLE_FRAMES = 2,
`ifdef DISPLAY_SEQ_TIMEOUT_EN
  parameter int LOCK_TIMEOUT = 1048576,
`endif
  parameter bit V_POL = 1'b0,
  parameter logic [1:0] DEFAULT_MODE = 2'd0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  input  logic       i_vs,
  input  logic       i_mode_req,
  input  logic [1:0] i_mode,
  output logic       o_mode_ack,
  output logic [1:0] o_mode,
  output logic       o_clk_rst,
  output logic       o_tim_rst,
  output logic       o_out_en,
  output logic       o_ready,
  output logic [2:0] o_state
);
  typedef enum logic [2:0] {CLK_RST = 3'd0, WAIT_LOCK = 3'd1, SETTLE = 3'd2, ACTIVE = 3'd3, DRAIN = 3'd4} state_t;
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int FW = $clog2(SETTLE_FRAMES) + 1;
  localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
  localparam logic [FW-1:0] F_LAST = FW'(SETTLE_FRAMES - 1);
  state_t state, state_n;
  logic [RW-1:0] rcnt;
  logic [FW-1:0] fcnt;
  logic [1:0] lk_s;
  logic [2:0] vs_s;
  logic lk, fs, ack_n, load_n, tout;
  assign lk = lk_s[1];
  assign o_state = state;
`ifdef DISPLAY_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  assign tout = tcnt == T_LAST;
  always_ff @(posedge i_clk)
    tcnt <= (i_rst || state != WAIT_LOCK || state_n != WAIT_LOCK) ? '0 : tcnt + TW'(1);
`else
  assign tout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    ack_n = 1'b0;
    load_n = 1'b0;
    case (state)
      CLK_RST: state_n = rcnt == R_LAST ? WAIT_LOCK : CLK_RST;
      WAIT_LOCK: state_n = lk ? SETTLE : tout ? CLK_RST : WAIT_LOCK;
      SETTLE: state_n = !lk ? CLK_RST : (fs && fcnt == F_LAST) ? ACTIVE : SETTLE;
      ACTIVE: begin
        state_n = !lk ? CLK_RST : (i_mode_req && i_mode != o_mode) ? DRAIN : ACTIVE;
        ack_n = lk && i_mode_req && i_mode == o_mode && !o_mode_ack;
      end
      DRAIN: begin
        state_n = (!lk || fs) ? CLK_RST : DRAIN;
        load_n = lk && fs;
      end
      default: state_n = CLK_RST;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= CLK_RST;
      rcnt <= '0;
      fcnt <= '0;
      lk_s <= '0;
      vs_s <= '0;
      fs <= 1'b0;
      o_mode <= DEFAULT_MODE;
      o_mode_ack <= 1'b0;
      o_clk_rst <= 1'b1;
      o_tim_rst <= 1'b1;
      o_out_en <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      lk_s <= {lk_s[0], i_locked};
      vs_s <= {vs_s[1:0], i_vs};
      fs <= vs_s[1] == V_POL && vs_s[2] != V_POL;
      state <= state_n;
      rcnt <= (state == CLK_RST && state_n == CLK_RST) ? rcnt + RW'(1) : '0;
      fcnt <= state == SETTLE ? fcnt + FW'(fs) : '0;
      if (load_n) o_mode <= i_mode;
      o_mode_ack <= ack_n || load_n;
      o_clk_rst <= state_n == CLK_RST;
      o_tim_rst <= state_n == CLK_RST || state_n == WAIT_LOCK;
      o_out_en <= state_n == ACTIVE;
      o_ready <= state_n == ACTIVE;
    end
  end
endmodule
